// File: rtl/mac_pkg.sv
// Shared widths and FSM state encoding for the sequential multiply-accumulate PE.
package mac_pkg;

    localparam int DEF_DATA_W = 4;
    localparam int DEF_ACC_W  = 10;
    localparam int PROD_W     = 2 * DEF_DATA_W;
    localparam int CNT_W      = $clog2(DEF_DATA_W);

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_MUL  = 2'd1;
    localparam state_t ST_ACC  = 2'd2;
    localparam state_t ST_HOLD = 2'd3;

endpackage

// File: rtl/mul_shift_add.sv
// Shift-add unsigned multiplier, one partial product per step; sequenced by the owning FSM.
module mul_shift_add
    import mac_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  step,
    input  logic [DATA_W-1:0]     a,
    input  logic [DATA_W-1:0]     b,
    output logic                  done,
    output logic [2*DATA_W-1:0]   product
);

    localparam int PW = 2 * DATA_W;
    localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(DATA_W - 1);

    logic [PW-1:0]     r_mcand;
    logic [PW-1:0]     r_prod;
    logic [DATA_W-1:0] r_mplier;
    logic [CW-1:0]     r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand  <= '0;
            r_prod   <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
        end else if (load) begin
            r_mcand  <= {{DATA_W{1'b0}}, a};
            r_mplier <= b;
            r_prod   <= '0;
            r_cnt    <= '0;
        end else if (step) begin
            if (r_mplier[0]) begin
                r_prod <= r_prod + r_mcand;
            end
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
        end
    end

    // Fixed step count: zero operands do not terminate early.
    assign done    = step && (r_cnt == LAST_CNT);
    assign product = r_prod;

endmodule

// File: rtl/mac_seq_4bit.sv
// Dot-product processing element: accepts A/B operand pairs, multiplies sequentially,
// accumulates, and emits one result per first..last pass over a valid/ready port.
//   state | meaning
//   IDLE  | waiting for an operand pair
//   MUL   | shift-add multiply, DATA_W steps
//   ACC   | add product into accumulator
//   HOLD  | result pending until consumer accepts
module mac_seq_4bit
    import mac_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              first,
    input  logic              last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  result,
    output logic              overflow,
    output logic              busy
);

    localparam int PW = 2 * DATA_W;

    state_t           r_state;
    logic             r_first_q;
    logic             r_last_q;
    logic             r_out_valid;
    logic             r_overflow;
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] r_result;

    logic             w_load;
    logic             w_step;
    logic             w_done;
    logic [PW-1:0]    w_product;
    logic [ACC_W-1:0] w_acc_base;
    logic [ACC_W:0]   w_acc_sum;

    assign w_load     = (r_state == ST_IDLE) && in_valid;
    assign w_step     = (r_state == ST_MUL);
    assign w_acc_base = r_first_q ? '0 : r_acc;
    assign w_acc_sum  = {1'b0, w_acc_base} + (ACC_W+1)'(w_product);

    mul_shift_add #(
        .DATA_W (DATA_W)
    ) u_mul (
        .clk     (clk),
        .rst_n   (clr),
        .load    (w_load),
        .step    (w_step),
        .a       (a),
        .b       (b),
        .done    (w_done),
        .product (w_product)
    );

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state     <= ST_IDLE;
            r_first_q   <= 1'b0;
            r_last_q    <= 1'b0;
            r_out_valid <= 1'b0;
            r_overflow  <= 1'b0;
            r_acc       <= '0;
            r_result    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_first_q <= first;
                        r_last_q  <= last;
                        r_state   <= ST_MUL;
                    end
                end
                ST_MUL: begin
                    if (w_done) begin
                        r_state <= ST_ACC;
                    end
                end
                ST_ACC: begin
                    r_acc      <= w_acc_sum[ACC_W-1:0];
                    r_overflow <= (r_first_q ? 1'b0 : r_overflow) | w_acc_sum[ACC_W];
                    if (r_last_q) begin
                        r_result    <= w_acc_sum[ACC_W-1:0];
                        r_out_valid <= 1'b1;
                        r_state     <= ST_HOLD;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign overflow  = r_overflow;

endmodule
